// File: rtl/fifo_chain_sync_pkg.sv
// rtl/fifo_chain_sync_pkg.sv - shared width helpers for fifo_chain_sync
// Depth, pointer, count and bank-index width derivations used by the top and its banks.
package fifo_chain_sync_pkg;

  function automatic int depth_total(input int n, input int d);
    return n * d;
  endfunction

  // Counter must hold 0..depth inclusive
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Bank index keeps at least one bit so N=1 builds without zero-width vectors
  function automatic int bank_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_chain_sync_bank.sv
// rtl/fifo_chain_sync_bank.sv - D x W simple dual-port RAM bank with registered read
// One write port and one read port; read data appears the cycle after re_i.
module fifo_chain_sync_bank #(
  parameter int W = 16,
  parameter int D = 256
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [$clog2(D)-1:0] waddr_i,
  input  logic [W-1:0]         wdata_i,
  input  logic                 re_i,
  input  logic [$clog2(D)-1:0] raddr_i,
  output logic [W-1:0]         rdata_o
);

  logic [W-1:0] mem_q [D];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_chain_sync.sv
// rtl/fifo_chain_sync.sv - single-clock FWFT FIFO over N RAM banks with thresholds and count
// Optional sticky protocol-error flag built only when FIFO_CHAIN_SYNC_ERR_EN is defined.
module fifo_chain_sync
  import fifo_chain_sync_pkg::*;
#(
  parameter int W       = 16,
  parameter int N       = 8,
  parameter int D       = 256,
  parameter int WThresh = depth_total(N, D) / 2,
  parameter int RThresh = depth_total(N, D) / 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    w_trigger,
  input  logic [W-1:0]                            w_data,
  output logic                                    w_ready,
  output logic                                    w_ready_thresh,
  input  logic                                    r_trigger,
  output logic [W-1:0]                            r_data,
  output logic                                    r_ready,
  output logic                                    r_ready_thresh,
  output logic [cnt_width(depth_total(N, D))-1:0] count,
  output logic                                    err
);

  localparam int DepthTotal = depth_total(N, D);
  localparam int CW         = cnt_width(DepthTotal);
  localparam int AW         = ptr_width(D);
  localparam int BW         = bank_width(N);
  localparam logic [CW-1:0] DepthC   = CW'(DepthTotal);
  localparam logic [CW-1:0] WThreshC = CW'(WThresh);
  localparam logic [CW-1:0] RThreshC = CW'(RThresh);
  localparam logic [BW-1:0] BankLast = BW'(N - 1);
  localparam logic [AW-1:0] AddrLast = AW'(D - 1);

  logic [CW-1:0] count_q, count_d, ram_cnt_q, ram_cnt_d;
  logic          w_ready_q, w_ready_thresh_q, r_ready_thresh_q;
  logic [AW-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [BW-1:0] wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, sel_bank_q;
  logic          rd_valid_q;
  logic          out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic [W-1:0]  out_data_q, out_data_d, skid_data_q, skid_data_d;

  logic          wr_en, rd_en, issue;
  logic [1:0]    fetched;
  logic [W-1:0]  ram_rdata;
  logic [W-1:0]  bank_rdata [N];

  assign wr_en     = w_trigger && w_ready_q;
  assign rd_en     = r_trigger && out_valid_q;
  // Words already fetched from RAM (in flight, output, skid); never let more than two land
  assign fetched   = 2'(rd_valid_q) + 2'(out_valid_q) + 2'(skid_valid_q);
  assign issue     = (ram_cnt_q != '0) && ((fetched - 2'(rd_en)) < 2'd2);
  assign ram_rdata = bank_rdata[sel_bank_q];

  always_comb begin
    count_d      = count_q + CW'(wr_en) - CW'(rd_en);
    ram_cnt_d    = ram_cnt_q + CW'(wr_en) - CW'(issue);
    wr_addr_d    = wr_addr_q;
    wr_bank_d    = wr_bank_q;
    rd_addr_d    = rd_addr_q;
    rd_bank_d    = rd_bank_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (wr_en) begin
      wr_addr_d = wr_addr_q + AW'(1);
      if (wr_addr_q == AddrLast) wr_bank_d = (wr_bank_q == BankLast) ? '0 : wr_bank_q + BW'(1);
    end
    if (issue) begin
      rd_addr_d = rd_addr_q + AW'(1);
      if (rd_addr_q == AddrLast) rd_bank_d = (rd_bank_q == BankLast) ? '0 : rd_bank_q + BW'(1);
    end

    // Output register refills from skid first to preserve order
    if (!out_valid_q || rd_en) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = rd_valid_q;
        if (rd_valid_q) skid_data_d = ram_rdata;
      end else begin
        out_valid_d = rd_valid_q;
        if (rd_valid_q) out_data_d = ram_rdata;
      end
    end else if (rd_valid_q) begin
      skid_valid_d = 1'b1;
      skid_data_d  = ram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q          <= '0;
      ram_cnt_q        <= '0;
      w_ready_q        <= 1'b0;
      w_ready_thresh_q <= 1'b0;
      r_ready_thresh_q <= 1'b0;
      wr_addr_q        <= '0;
      wr_bank_q        <= '0;
      rd_addr_q        <= '0;
      rd_bank_q        <= '0;
      sel_bank_q       <= '0;
      rd_valid_q       <= 1'b0;
      out_valid_q      <= 1'b0;
      out_data_q       <= '0;
      skid_valid_q     <= 1'b0;
      skid_data_q      <= '0;
    end else begin
      count_q          <= count_d;
      ram_cnt_q        <= ram_cnt_d;
      w_ready_q        <= count_d < DepthC;
      w_ready_thresh_q <= (DepthC - count_d) >= WThreshC;
      r_ready_thresh_q <= count_d >= RThreshC;
      wr_addr_q        <= wr_addr_d;
      wr_bank_q        <= wr_bank_d;
      rd_addr_q        <= rd_addr_d;
      rd_bank_q        <= rd_bank_d;
      rd_valid_q       <= issue;
      if (issue) sel_bank_q <= rd_bank_q;
      out_valid_q      <= out_valid_d;
      out_data_q       <= out_data_d;
      skid_valid_q     <= skid_valid_d;
      skid_data_q      <= skid_data_d;
    end
  end

  for (genvar b = 0; b < N; b++) begin : g_bank
    fifo_chain_sync_bank #(.W(W), .D(D)) u_bank (
      .clk     (clk),
      .we_i    (wr_en && (wr_bank_q == BW'(b))),
      .waddr_i (wr_addr_q),
      .wdata_i (w_data),
      .re_i    (issue && (rd_bank_q == BW'(b))),
      .raddr_i (rd_addr_q),
      .rdata_o (bank_rdata[b])
    );
  end

`ifdef FIFO_CHAIN_SYNC_ERR_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else if ((w_trigger && !w_ready_q) || (r_trigger && !out_valid_q)) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign w_ready        = w_ready_q;
  assign w_ready_thresh = w_ready_thresh_q;
  assign r_ready_thresh = r_ready_thresh_q;
  assign r_ready        = out_valid_q;
  assign r_data         = out_data_q;
  assign count          = count_q;

endmodule
